// File: rtl/axis_uart_rx_os_pkg.sv
// rtl/axis_uart_rx_os_pkg.sv - shared encodings for the oversampling UART receiver
// FSM states, tuser bit positions and parity type codes.
package axis_uart_rx_os_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_WAIT1  = 3'd5;

    localparam int TUSER_FRAME  = 0;
    localparam int TUSER_PARITY = 1;
    localparam int TUSER_BREAK  = 2;

    localparam logic [1:0] PAR_EVEN  = 2'd0;
    localparam logic [1:0] PAR_ODD   = 2'd1;
    localparam logic [1:0] PAR_MARK  = 2'd2;
    localparam logic [1:0] PAR_SPACE = 2'd3;

    // Parity bit the transmitter should have sent, given the XOR of the data word.
    function automatic logic expected_parity(input logic [1:0] ptype, input logic data_xor);
        logic bit_v;
        case (ptype)
            PAR_EVEN:  bit_v = data_xor;
            PAR_ODD:   bit_v = ~data_xor;
            PAR_MARK:  bit_v = 1'b1;
            PAR_SPACE: bit_v = 1'b0;
            default:   bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

endpackage

// File: rtl/axis_uart_rx_os_if.sv
// rtl/axis_uart_rx_os_if.sv - AXI-Stream word interface carrying received UART words
// tuser carries {break, parity_err, frame_err}.
interface axis_uart_rx_os_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tdata;
    logic [2:0]           tuser;
    logic                 tvalid;
    logic                 tready;

    modport master (
        output tdata,
        output tuser,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_uart_rx_os_sync.sv
// rtl/axis_uart_rx_os_sync.sv - multi-stage synchroniser for the asynchronous rxd pad
// Resets to 1 so an idle line never looks like a start bit after reset.
module axis_uart_rx_os_sync #(
    parameter int DELAY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DELAY-1:0] chain_q;
    logic [DELAY-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[DELAY-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '1;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[DELAY-1];

endmodule

// File: rtl/axis_uart_rx_os.sv
// rtl/axis_uart_rx_os.sv - oversampling UART receiver with AXI-Stream master output
// 3-sample majority vote at bit centre, false-start rejection, frame/parity/break flags, overrun.
module axis_uart_rx_os
    import axis_uart_rx_os_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_ENA  = 0,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int DELAY       = 3
) (
    input  logic               aclk,
    input  logic               arst,
    input  logic               uart_ena,
    input  logic               rxd,
    axis_uart_rx_os_if.master  m_axis,
    output logic               overrun
);

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("axis_uart_rx_os: OVERSAMPLE must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("axis_uart_rx_os: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("axis_uart_rx_os: STOP_BITS must be 1..2");
    end
    if (PARITY_TYPE < 0 || PARITY_TYPE > 3) begin : g_bad_parity_type
        $error("axis_uart_rx_os: PARITY_TYPE must be 0..3");
    end
    if (DELAY < 2) begin : g_bad_delay
        $error("axis_uart_rx_os: DELAY must be >= 2");
    end

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_S2   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]    BITS_LAST_DATA = 4'(DATA_BITS);
    localparam logic [3:0]    BITS_LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [1:0]    PTYPE = 2'(PARITY_TYPE);

    logic rxd_s;

    axis_uart_rx_os_sync #(.DELAY(DELAY)) u_sync (
        .clk (aclk),
        .rst (arst),
        .d   (rxd),
        .q   (rxd_s)
    );

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_err_q, par_err_d;
    logic                 fe_q, fe_d;
    logic                 ones_q, ones_d;
    logic                 load_q, load_d;
    logic [DATA_BITS-1:0] pend_data_q, pend_data_d;
    logic [2:0]           pend_user_q, pend_user_d;

    logic [DATA_BITS-1:0] tdata_q, tdata_d;
    logic [2:0]           tuser_q, tuser_d;
    logic                 tvalid_q, tvalid_d;
    logic                 overrun_q, overrun_d;

    logic vote;
    logic wrap;
    logic at_vote;
    logic fe_now;

    // The third sample is taken live; the first two were captured on the preceding ticks.
    assign vote    = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);
    assign wrap    = (cnt_q == CNT_LAST);
    assign at_vote = (cnt_q == CNT_S2);
    assign fe_now  = fe_q | ~vote;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        data_d      = data_q;
        par_err_d   = par_err_q;
        fe_d        = fe_q;
        ones_d      = ones_q;
        load_d      = 1'b0;
        pend_data_d = pend_data_q;
        pend_user_d = pend_user_q;

        if (uart_ena) begin
            if (state_q == ST_IDLE || state_q == ST_WAIT1) begin
                cnt_d = '0;
            end else begin
                cnt_d = wrap ? '0 : cnt_q + CW'(1);
            end
            if (cnt_q == CNT_S0) s0_d = rxd_s;
            if (cnt_q == CNT_S1) s1_d = rxd_s;

            case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_d   = ST_START;
                        bit_cnt_d = '0;
                        par_err_d = 1'b0;
                        fe_d      = 1'b0;
                        ones_d    = 1'b0;
                    end
                end
                ST_START: begin
                    if (at_vote && vote) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (wrap) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (at_vote) begin
                        data_d    = {vote, data_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        ones_d    = ones_q | vote;
                    end
                    if (wrap && bit_cnt_q == BITS_LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_ENA != 0) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (at_vote) begin
                        par_err_d = (vote != expected_parity(PTYPE, ^data_q));
                        ones_d    = ones_q | vote;
                    end
                    if (wrap) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (at_vote) begin
                        fe_d = fe_now;
                        // Leaving at the centre of the last stop bit lets a back-to-back start edge be seen.
                        if (bit_cnt_q == BITS_LAST_STOP) begin
                            load_d                   = 1'b1;
                            pend_data_d              = data_q;
                            pend_user_d[TUSER_FRAME]  = fe_now;
                            pend_user_d[TUSER_PARITY] = par_err_q;
                            pend_user_d[TUSER_BREAK]  = fe_now & ~ones_q;
                            state_d                  = fe_now ? ST_WAIT1 : ST_IDLE;
                            cnt_d                    = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_WAIT1: begin
                    if (rxd_s) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        tdata_d   = tdata_q;
        tuser_d   = tuser_q;
        tvalid_d  = tvalid_q;
        overrun_d = 1'b0;
        if (load_q) begin
            // A held, unconsumed word wins; a word being consumed this cycle is replaced in place.
            if (tvalid_q && !m_axis.tready) begin
                overrun_d = 1'b1;
            end else begin
                tdata_d  = pend_data_q;
                tuser_d  = pend_user_q;
                tvalid_d = 1'b1;
            end
        end else if (tvalid_q && m_axis.tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            s0_q        <= 1'b1;
            s1_q        <= 1'b1;
            data_q      <= '0;
            par_err_q   <= 1'b0;
            fe_q        <= 1'b0;
            ones_q      <= 1'b0;
            load_q      <= 1'b0;
            pend_data_q <= '0;
            pend_user_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            data_q      <= data_d;
            par_err_q   <= par_err_d;
            fe_q        <= fe_d;
            ones_q      <= ones_d;
            load_q      <= load_d;
            pend_data_q <= pend_data_d;
            pend_user_q <= pend_user_d;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            tdata_q   <= '0;
            tuser_q   <= '0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tdata_q   <= tdata_d;
            tuser_q   <= tuser_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign overrun       = overrun_q;

endmodule
